// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: owns the double-buffered framebuffer RAM port behind a 640x480 VGA timing block.
// Define FB_CLEAR_EN to build the back-bank clear sweep (CLEAR state); otherwise clear_req is ignored.
module vga_fb_arbiter #(
  parameter int          FB_W        = 160,
  parameter int          FB_H        = 120,
  parameter int          SHIFT       = 2,
  parameter int          ADDR_W      = 15,
  parameter logic [11:0] CLEAR_COLOR = 12'h000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic              Vsync,
  output logic [11:0]       pix_data,
  input  logic              wr_req,
  input  logic [7:0]        wr_x,
  input  logic [6:0]        wr_y,
  input  logic [11:0]       wr_data,
  output logic              wr_ack,
  input  logic              swap_req,
  output logic              swap_pend,
  output logic              swap_done,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic [ADDR_W:0]   mem_addr,
  output logic              mem_we,
  output logic [11:0]       mem_wdata,
  input  logic [11:0]       mem_rdata
);

  localparam logic [9:0]        NO_FETCH = 10'd1000;
  localparam logic [ADDR_W-1:0] FB_W_A   = ADDR_W'(FB_W);

  logic              front_q, front_d;
  logic              swap_pend_q, swap_pend_d;
  logic              swap_done_q, swap_done_d;
  logic              vs_q;
  logic              rd_v_q;
  logic              fetch;
  logic              frame_start;
  logic              busy;
  logic              wr_in_range;
  logic [ADDR_W-1:0] fetch_off;
  logic [ADDR_W-1:0] wr_off;
  logic [ADDR_W:0]   addr_c;
  logic              we_c;
  logic [11:0]       wdata_c;
  logic              ack_c;

`ifdef FB_CLEAR_EN
  localparam logic [ADDR_W-1:0] LAST_OFF = ADDR_W'(FB_W * FB_H - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  assign busy = (state_q == CLEAR);
`else
  logic unused_cfg;

  assign busy       = 1'b0;
  assign unused_cfg = clear_req ^ (^CLEAR_COLOR);
`endif

  assign fetch       = (pix_x != NO_FETCH) && (pix_y != NO_FETCH);
  assign fetch_off   = ADDR_W'(pix_y >> SHIFT) * FB_W_A + ADDR_W'(pix_x >> SHIFT);
  assign wr_off      = ADDR_W'(wr_y) * FB_W_A + ADDR_W'(wr_x);
  assign wr_in_range = (32'(wr_x) < FB_W) && (32'(wr_y) < FB_H);
  assign frame_start = vs_q & ~Vsync;

  // A pending swap waits for a frame start that is not inside a clear sweep.
  always_comb begin
    front_d     = front_q;
    swap_pend_d = swap_pend_q;
    swap_done_d = 1'b0;
    if (frame_start && swap_pend_q && !busy) begin
      front_d     = ~front_q;
      swap_pend_d = 1'b0;
      swap_done_d = 1'b1;
    end else if (swap_req) begin
      swap_pend_d = 1'b1;
    end
  end

  always_comb begin
    addr_c  = '0;
    we_c    = 1'b0;
    wdata_c = 12'h000;
    ack_c   = 1'b0;
`ifdef FB_CLEAR_EN
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
`endif
    if (fetch) begin
      addr_c = {front_q, fetch_off};
    end
`ifdef FB_CLEAR_EN
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end else if (!fetch && wr_req) begin
          ack_c = 1'b1;
          if (wr_in_range) begin
            we_c    = 1'b1;
            addr_c  = {~front_q, wr_off};
            wdata_c = wr_data;
          end
        end
      end
      CLEAR: begin
        if (!fetch) begin
          we_c      = 1'b1;
          addr_c    = {~front_q, clr_cnt_q};
          wdata_c   = CLEAR_COLOR;
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
          if (clr_cnt_q == LAST_OFF) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
`else
    if (!fetch && wr_req) begin
      ack_c = 1'b1;
      if (wr_in_range) begin
        we_c    = 1'b1;
        addr_c  = {~front_q, wr_off};
        wdata_c = wr_data;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      front_q     <= 1'b0;
      swap_pend_q <= 1'b0;
      swap_done_q <= 1'b0;
      vs_q        <= 1'b1;
      rd_v_q      <= 1'b0;
`ifdef FB_CLEAR_EN
      state_q     <= IDLE;
      clr_cnt_q   <= '0;
`endif
    end else begin
      front_q     <= front_d;
      swap_pend_q <= swap_pend_d;
      swap_done_q <= swap_done_d;
      vs_q        <= Vsync;
      rd_v_q      <= fetch;
`ifdef FB_CLEAR_EN
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
`endif
    end
  end

  // Combinational outputs are held at zero while reset is asserted.
  assign mem_addr   = rst_n ? addr_c  : '0;
  assign mem_we     = rst_n ? we_c    : 1'b0;
  assign mem_wdata  = rst_n ? wdata_c : 12'h000;
  assign wr_ack     = rst_n ? ack_c   : 1'b0;
  assign pix_data   = (rst_n && rd_v_q) ? mem_rdata : 12'h000;
  assign swap_pend  = swap_pend_q;
  assign swap_done  = swap_done_q;
  assign clear_busy = busy;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: a behavioural model queues per-cycle expectations, a monitor checks them.
// Clear behaviour is expected only when FB_CLEAR_EN is defined for the build.
`timescale 1ns/1ps
module tb_vga_fb_arbiter;
`ifdef FB_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif
  localparam int FB_PIX = 160 * 120;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  pix_x, pix_y;
  logic        Vsync;
  logic [11:0] pix_data;
  logic        wr_req;
  logic [7:0]  wr_x;
  logic [6:0]  wr_y;
  logic [11:0] wr_data;
  logic        wr_ack;
  logic        swap_req, swap_pend, swap_done;
  logic        clear_req, clear_busy;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .Vsync(Vsync),
    .pix_data(pix_data), .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .wr_ack(wr_ack), .swap_req(swap_req), .swap_pend(swap_pend), .swap_done(swap_done),
    .clear_req(clear_req), .clear_busy(clear_busy), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous RAM with one cycle of read latency.
  logic [11:0] ram  [0:65535];
  logic [11:0] mmem [0:65535];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct packed {
    logic        chk_addr;
    logic        chk_wd;
    logic [15:0] addr;
    logic        we;
    logic [11:0] wdata;
    logic        ack;
    logic [11:0] pix;
    logic        pend;
    logic        done;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   clr_writes = 0;

  // Model state: which bank is displayed, pending swap, remaining clear pixels.
  int          m_front = 0;
  bit          m_pend = 0, m_done = 0, m_vs_prev = 1, m_rdv = 0, m_ack = 0;
  int          m_clr_left = 0;
  logic [11:0] m_rdval = 12'h000;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mem_we && clear_busy) clr_writes++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("wr_ack", int'(wr_ack), int'(e.ack));
      chk("mem_we", int'(mem_we), int'(e.we));
      if (e.chk_addr) chk("mem_addr", int'(mem_addr), int'(e.addr));
      if (e.chk_wd)   chk("mem_wdata", int'(mem_wdata), int'(e.wdata));
      chk("pix_data", int'(pix_data), int'(e.pix));
      chk("swap_pend", int'(swap_pend), int'(e.pend));
      chk("swap_done", int'(swap_done), int'(e.done));
      chk("clear_busy", int'(clear_busy), int'(e.busy));
      if (e.ack)  $display("wr_ack: x=%0d y=%0d we=%0d addr=0x%04h data=0x%03h", wr_x, wr_y, mem_we, mem_addr, mem_wdata);
      if (e.done) $display("swap_done: t=%0t", $time);
    end
  end

  // One clock cycle: predict this cycle's outputs, then advance the model across the edge.
  task automatic step();
    exp_t e;
    bit   fetch, busy, inr, fs, apply;
    int   faddr, woff;
    e     = '0;
    m_ack = 1'b0;
    fetch = (pix_x != 10'd1000) && (pix_y != 10'd1000);
    faddr = m_front * 32768 + (int'(pix_y) / 4) * 160 + int'(pix_x) / 4;
    woff  = int'(wr_y) * 160 + int'(wr_x);
    inr   = (int'(wr_x) < 160) && (int'(wr_y) < 120);
    busy  = (m_clr_left > 0);
    if (!rst_n) begin
      e.chk_addr = 1'b1;
      e.chk_wd   = 1'b1;
      exp_q.push_back(e);
      @(posedge clk);
      m_front = 0; m_pend = 0; m_done = 0; m_clr_left = 0;
      m_vs_prev = 1; m_rdv = 0; m_rdval = 12'h000;
      #1;
      return;
    end
    e.pend = m_pend;
    e.done = m_done;
    e.busy = busy;
    e.pix  = m_rdv ? m_rdval : 12'h000;
    if (fetch) begin
      e.chk_addr = 1'b1;
      e.addr     = 16'(faddr);
    end else if (busy) begin
      e.chk_addr = 1'b1; e.chk_wd = 1'b1; e.we = 1'b1; e.wdata = 12'h000;
      e.addr     = 16'((1 - m_front) * 32768 + (FB_PIX - m_clr_left));
    end else if (!(CLEAR_EN && clear_req) && wr_req) begin
      e.ack = 1'b1;
      m_ack = 1'b1;
      if (inr) begin
        e.chk_addr = 1'b1; e.chk_wd = 1'b1; e.we = 1'b1; e.wdata = wr_data;
        e.addr     = 16'((1 - m_front) * 32768 + woff);
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    if (fetch) m_rdval = mmem[faddr];
    m_rdv = fetch;
    if (e.we) mmem[e.addr] = e.wdata;
    fs     = m_vs_prev && !Vsync;
    apply  = fs && m_pend && !busy;
    m_done = apply;
    if (apply) begin
      m_front = 1 - m_front;
      m_pend  = 1'b0;
    end else if (swap_req) begin
      m_pend = 1'b1;
    end
    if (busy) begin
      if (!fetch) m_clr_left--;
    end else if (CLEAR_EN && clear_req) begin
      m_clr_left = FB_PIX;
    end
    m_vs_prev = Vsync;
    #1;
  endtask

  task automatic do_write(input logic [7:0] x, input logic [6:0] y, input logic [11:0] d);
    wr_req = 1'b1; wr_x = x; wr_y = y; wr_data = d;
    for (int i = 0; i < 50; i++) begin
      step();
      if (m_ack) break;
    end
    if (!m_ack) begin
      n_checks++; n_fail++;
      $display("FAIL wr_ack_timeout: got no ack, expected ack for x=%0d y=%0d", x, y);
    end
    wr_req = 1'b0;
  endtask

  task automatic vsync_fall();
    Vsync = 1'b0; step(); step();
    Vsync = 1'b1; step(); step();
  endtask

  initial begin
    int vs_cnt;
    int r;
    bit done_loop;
    for (int i = 0; i < 65536; i++) begin
      ram[i]  = 12'(i) ^ 12'h5A5;
      mmem[i] = 12'(i) ^ 12'h5A5;
    end
    ram[161]  = 12'hF0F;
    mmem[161] = 12'hF0F;
    rst_n = 1'b0; pix_x = 10'd4; pix_y = 10'd4; Vsync = 1'b1;
    wr_req = 1'b0; wr_x = 8'd0; wr_y = 7'd0; wr_data = 12'h000;
    swap_req = 1'b0; clear_req = 1'b0;
    @(posedge clk); #1;
    repeat (3) step();
    rst_n = 1'b1;

    // Fetch path, then a no-fetch cycle.
    pix_x = 10'd4; pix_y = 10'd4; step();
    pix_x = 10'd1000; step();
    step();

    // Write held off by fetch cycles, then granted.
    wr_req = 1'b1; wr_x = 8'd10; wr_y = 7'd2; wr_data = 12'h0F0;
    pix_x = 10'd0; pix_y = 10'd0;
    repeat (3) step();
    pix_x = 10'd1000;
    do_write(8'd10, 7'd2, 12'h0F0);
    do_write(8'd200, 7'd5, 12'h111);
    do_write(8'd5, 7'd120, 12'h222);
    do_write(8'd159, 7'd119, 12'h333);
    do_write(8'd160, 7'd0, 12'h444);

    // Mid-frame swap request, applied at the Vsync fall.
    swap_req = 1'b1; step(); swap_req = 1'b0;
    repeat (5) step();
    vsync_fall();
    pix_x = 10'd4;  pix_y = 10'd4; step();
    pix_x = 10'd40; pix_y = 10'd8; step();
    pix_x = 10'd1000; step();
    do_write(8'd10, 7'd2, 12'hABC);
    pix_x = 10'd40; pix_y = 10'd8; step();
    pix_x = 10'd1000; step();

    // Swap requested on the same cycle as a frame start.
    Vsync = 1'b0; swap_req = 1'b1; step(); swap_req = 1'b0; step();
    Vsync = 1'b1; repeat (3) step();
    vsync_fall();

    // Randomized traffic.
    vs_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      pix_x = 10'($urandom_range(0, 639));
      pix_y = 10'($urandom_range(0, 479));
      r = int'($urandom_range(0, 3));
      if (r == 0) pix_x = 10'd1000;
      else if (r == 1) pix_y = 10'd1000;
      if (!wr_req && $urandom_range(0, 2) == 0) begin
        wr_req  = 1'b1;
        wr_x    = 8'($urandom_range(0, 175));
        wr_y    = 7'($urandom_range(0, 127));
        wr_data = 12'($urandom);
      end
      swap_req = ($urandom_range(0, 63) == 0);
      if (vs_cnt > 0) begin
        Vsync = 1'b0; vs_cnt--;
      end else if ($urandom_range(0, 149) == 0) begin
        Vsync = 1'b0; vs_cnt = 2;
      end else begin
        Vsync = 1'b1;
      end
      step();
      if (m_ack) wr_req = 1'b0;
    end
    swap_req = 1'b0; Vsync = 1'b1; pix_x = 10'd1000;
    if (wr_req) do_write(wr_x, wr_y, wr_data);
    repeat (4) step();

    // Clear sweep with a concurrent writer, a swap request, and a frame start mid-sweep.
    clr_writes = 0;
    done_loop  = 1'b0;
    clear_req = 1'b1; wr_req = 1'b1; wr_x = 8'd3; wr_y = 7'd3; wr_data = 12'h123;
    for (int i = 0; i < 30000; i++) begin
      if (i % 7 == 3) begin
        pix_x = 10'($urandom_range(0, 639)); pix_y = 10'($urandom_range(0, 479));
      end else begin
        pix_x = 10'd1000;
      end
      swap_req = (i == 50);
      Vsync    = !(i == 1000 || i == 1001);
      step();
      clear_req = 1'b0;
      if (m_ack) wr_req = 1'b0;
      if (i > 1100 && m_clr_left == 0 && !wr_req) begin
        done_loop = 1'b1;
        break;
      end
    end
    chk("clear_loop_done", int'(done_loop), 1);
    swap_req = 1'b0; Vsync = 1'b1; pix_x = 10'd1000; wr_req = 1'b0;
    repeat (3) step();
    chk("clear_write_count", clr_writes, CLEAR_EN ? FB_PIX : 0);
    vsync_fall();
    pix_x = 10'd4; pix_y = 10'd4; step();
    pix_x = 10'd1000; step();

    // Asynchronous reset in the middle of a clear with a swap pending.
    clear_req = 1'b1; step(); clear_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      swap_req = (i == 5);
      step();
    end
    swap_req = 1'b0;
    rst_n = 1'b0; pix_x = 10'd4; pix_y = 10'd4;
    repeat (2) step();
    rst_n = 1'b1; pix_x = 10'd1000;
    clr_writes = 0;
    for (int i = 0; i < 60; i++) begin
      Vsync = !(i == 20 || i == 21);
      step();
    end
    pix_x = 10'd4; pix_y = 10'd4; step();
    pix_x = 10'd1000; step();
    chk("post_reset_clear_writes", clr_writes, 0);
    chk("scoreboard_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
